codec_clkgen: RTL and testbench



---
 rtl/codec_pkg.sv | 24 ++
 rtl/codec_clkgen_if.sv | 31 +++
 rtl/codec_clkgen.sv | 110 +++++++++++
 tb/tb_codec_clkgen.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared types and constants for the codec clock generator.
package codec_pkg;

  // Power-up sequence of the codec interface.
  typedef enum logic [1:0] {
    PDN_LOW = 2'd0,
    SETTLE  = 2'd1,
    RUN     = 2'd2
  } codec_seq_t;

  // Frame and bit-clock ratios relative to the 256fs system clock.
  localparam int FS_DIV   = 256;
  localparam int BICK_DIV = 4;

  // Divider geometry derived from the ratios above.
  localparam int DIV_W    = $clog2(FS_DIV);
  localparam int BICK_BIT = $clog2(BICK_DIV) - 1;
  localparam int LRCK_BIT = DIV_W - 1;

  // 100 us power-down hold and 1 ms settle time at 12 MHz.
  localparam int DEF_PDN_LOW_CYCLES = 1200;
  localparam int DEF_SETTLE_CYCLES  = 12000;

endpackage

// File: rtl/codec_clkgen_if.sv
// Control/status bundle between the codec clock generator and the audio core.
interface codec_clkgen_if;

  logic restart_in;
  logic pdn_o;
  logic bick_o;
  logic lrck_o;
  logic sample_stb_o;
  logic ready_o;

  // Clock generator side: takes the restart request, drives codec pins and status.
  modport master (
    input  restart_in,
    output pdn_o,
    output bick_o,
    output lrck_o,
    output sample_stb_o,
    output ready_o
  );

  // Audio core side.
  modport slave (
    output restart_in,
    input  pdn_o,
    input  bick_o,
    input  lrck_o,
    input  sample_stb_o,
    input  ready_o
  );

endinterface

// File: rtl/codec_clkgen.sv
// Codec power-up sequencer and serial clock generator.
//
// state   | meaning
// --------+-------------------------------------------------------------
// PDN_LOW | codec held in power-down, clocks static low, tcnt counts hold
// SETTLE  | pdn released, clocks running, waiting out settle time
// RUN     | clocks running, frame strobe and ready presented to audio core
//
// RUN is entered only on a divider wrap so the first RUN cycle is a frame
// start. Every output comes straight from a flop: no input reaches an output
// without passing through a register.
module codec_clkgen
  import codec_pkg::*;
#(
  parameter int PDN_LOW_CYCLES = DEF_PDN_LOW_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int CNT_W          = 16
) (
  input logic             clk_in,
  input logic             rst_n_in,
  codec_clkgen_if.master  bus
);

  localparam logic [CNT_W-1:0] PDN_LAST    = CNT_W'(PDN_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TCNT_ONE    = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(FS_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);

  codec_seq_t       state, state_nxt;
  logic [CNT_W-1:0] tcnt, tcnt_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             pdn_q;
  logic             ready_q;
  logic             sample_stb;

  // State, sequencing counter and clock divider registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= PDN_LOW;
      tcnt    <= '0;
      div_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tcnt    <= tcnt_nxt;
      div_cnt <= div_nxt;
    end
  end

  // Next-state logic; restart overrides every terminal-count transition.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    div_nxt   = div_cnt;
    if (bus.restart_in) begin
      state_nxt = PDN_LOW;
      tcnt_nxt  = '0;
      div_nxt   = '0;
    end else begin
      case (state)
        PDN_LOW: begin
          div_nxt = '0;
          if (tcnt == PDN_LAST) begin
            state_nxt = SETTLE;
            tcnt_nxt  = '0;
          end else begin
            tcnt_nxt = tcnt + TCNT_ONE;
          end
        end
        SETTLE: begin
          div_nxt = div_cnt + DIV_ONE;
          if (tcnt != SETTLE_LAST) begin
            tcnt_nxt = tcnt + TCNT_ONE;
          end
          if ((tcnt == SETTLE_LAST) && (div_cnt == DIV_LAST)) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          div_nxt = div_cnt + DIV_ONE;
        end
        default: begin
          state_nxt = PDN_LOW;
          tcnt_nxt  = '0;
          div_nxt   = '0;
        end
      endcase
    end
  end

  // Status flags registered from the next state so they change with the state itself.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pdn_q      <= 1'b0;
      ready_q    <= 1'b0;
      sample_stb <= 1'b0;
    end else begin
      pdn_q      <= (state_nxt != PDN_LOW);
      ready_q    <= (state_nxt == RUN);
      sample_stb <= (state_nxt == RUN) && (div_nxt == '0);
    end
  end

  assign bus.pdn_o        = pdn_q;
  assign bus.bick_o       = div_cnt[BICK_BIT];
  assign bus.lrck_o       = div_cnt[LRCK_BIT];
  assign bus.sample_stb_o = sample_stb;
  assign bus.ready_o      = ready_q;

endmodule

// File: tb/tb_codec_clkgen.sv
// Self-checking bench for codec_clkgen: a short-settle and a long-settle
// instance share clock, reset and restart; a timeline model predicts outputs.
module tb_codec_clkgen;
  import codec_pkg::*;

  localparam int P  = 4;
  localparam int SA = 8;
  localparam int SB = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart = 1'b0;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int rise_t;
  int hold;

  codec_clkgen_if if_a ();
  codec_clkgen_if if_b ();

  assign if_a.restart_in = restart;
  assign if_b.restart_in = restart;

  codec_clkgen #(.PDN_LOW_CYCLES(P), .SETTLE_CYCLES(SA), .CNT_W(16)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .bus(if_a)
  );
  codec_clkgen #(.PDN_LOW_CYCLES(P), .SETTLE_CYCLES(SB), .CNT_W(16)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .bus(if_b)
  );

  always #5 clk = ~clk;

  // Edges elapsed since the sequence last started (reset or restart).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else if (restart) t <= 0;
    else t <= t + 1;
  end

  // Cycles after pdn rise until RUN: first frame boundary not before settle ends.
  function automatic int run_offset(int s);
    int k;
    k = FS_DIV;
    while (k < s) k += FS_DIV;
    return k;
  endfunction

  // Expected {pdn, bick, lrck, stb, ready} after tt edges of the sequence.
  function automatic logic [4:0] model(int tt, int s);
    int  div;
    logic run;
    if (tt < P) return 5'b0;
    div = (tt - P) % FS_DIV;
    run = (tt >= P + run_offset(s));
    return {1'b1, div[1], div[7], run && (div == 0), run};
  endfunction

  function automatic logic [4:0] out_a();
    return {if_a.pdn_o, if_a.bick_o, if_a.lrck_o, if_a.sample_stb_o, if_a.ready_o};
  endfunction

  function automatic logic [4:0] out_b();
    return {if_b.pdn_o, if_b.bick_o, if_b.lrck_o, if_b.sample_stb_o, if_b.ready_o};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_a"}, out_a(), model(t, SA));
    check({tag, "_b"}, out_b(), model(t, SB));
  endtask

  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_both(tag);
    end
  endtask

  initial begin
    // Held in reset: everything low.
    step(3, "in_reset");
    check("reset_zero_a", out_a(), 5'b0);
    check("reset_zero_b", out_b(), 5'b0);

    // Release and watch the power-down window edge by edge.
    rst_n = 1'b1;
    step(P - 1, "pdn_window");
    check("pdn_last_low", {4'b0, if_a.pdn_o}, 5'b0);
    step(1, "pdn_rise");
    check("pdn_high", {4'b0, if_a.pdn_o}, 5'b1);
    step(1, "bick_pre");
    check("bick_pre_low", {4'b0, if_a.bick_o}, 5'b0);
    step(1, "bick_rise");
    check("bick_first_rise", {4'b0, if_a.bick_o}, 5'b1);

    // Bounded wait for ready on the short-settle instance.
    rise_t = -1;
    for (int i = 0; i < 400; i++) begin
      if (if_a.ready_o) begin
        rise_t = t;
        break;
      end
      step(1, "to_run");
    end
    check("ready_rise_time", 5'(rise_t == P + 256), 5'b1);
    check("first_run_stb", {4'b0, if_a.sample_stb_o}, 5'b1);
    check("long_settle_not_ready", {4'b0, if_b.ready_o}, 5'b0);

    // Long-settle instance reaches RUN at a later wrap; several frames of both.
    step(1300, "run_frames");

    // Random restart pulses, sometimes held for several cycles.
    for (int r = 0; r < 3; r++) begin
      step($urandom_range(900, 50), "pre_restart");
      restart = 1'b1;
      hold = $urandom_range(3, 1);
      step(hold, "restart_held");
      restart = 1'b0;
      step(P + 300, "after_restart");
    end

    // Restart exactly on the SETTLE->RUN terminal edge of the short instance.
    restart = 1'b1;
    step(1, "align");
    restart = 1'b0;
    step(P + 255, "to_terminal");
    restart = 1'b1;
    step(1, "terminal_restart");
    check("no_run_on_restart", {4'b0, if_a.ready_o}, 5'b0);
    restart = 1'b0;
    step(P + 260, "rerun");

    // Asynchronous reset in RUN, between edges.
    step($urandom_range(200, 10), "pre_async");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a", out_a(), 5'b0);
    check("async_rst_b", out_b(), 5'b0);
    @(negedge clk);
    check_both("async_hold");
    step(3, "async_hold");
    rst_n = 1'b1;
    step(P + 3 * 256 + 700, "replay");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
